// File: rtl/gradient_pkg.sv
// Shared constants and types for the gradient ROM arbiter.
// Default widths and the requester IDs carried on the response tag.
package gradient_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 24;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic: round-robin with a strict A-priority override.
// Ports: clk, reset, prio_a, req_a/req_b in; gnt_a/gnt_b/gnt_id out.
import gradient_pkg::*;

module rr_arbiter2 (
    input  logic    clk,
    input  logic    reset,
    input  logic    prio_a,
    input  logic    req_a,
    input  logic    req_b,
    output logic    gnt_a,
    output logic    gnt_b,
    output req_id_e gnt_id
);

    req_id_e last_grant;

    // A tie goes to A under priority mode, or when B won the last tie.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (prio_a || (last_grant == REQ_B)) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
        gnt_id = gnt_b ? REQ_B : REQ_A;
    end

    // Reset to B so the first tie after reset goes to A.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_B;
        end else if (gnt_a || gnt_b) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/gradient_rom_arbiter.sv
// Shares one registered single-port gradient ROM between two renderers.
// Ports: A/B valid-ready request, tagged responses, rom_addr out, rom_dout in.
import gradient_pkg::*;

module gradient_rom_arbiter #(
    parameter int ADDR_WIDTH = gradient_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = gradient_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prio_a,
    input  logic                  a_req_valid,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    output logic                  a_req_ready,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_req_valid,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_req_ready,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    logic                  gnt_a;
    logic                  gnt_b;
    req_id_e               gnt_id;
    logic                  xfer;
    logic                  xfer_ok;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  rsp_tag_valid;
    req_id_e               rsp_tag_id;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .prio_a (prio_a),
        .req_a  (a_req_valid),
        .req_b  (b_req_valid),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .gnt_id (gnt_id)
    );

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    // A grant only exists with its valid, so any grant is a transfer.
    assign xfer     = gnt_a | gnt_b;
    assign xfer_ok  = xfer & ~reset;
    assign gnt_addr = gnt_b ? b_req_addr : a_req_addr;

    // Hold the last address between grants so the ROM input stays quiet.
    assign rom_addr = xfer_ok ? gnt_addr : addr_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold     <= '0;
            rsp_tag_valid <= 1'b0;
            rsp_tag_id    <= REQ_A;
        end else begin
            if (xfer) begin
                addr_hold <= gnt_addr;
            end
            rsp_tag_valid <= xfer;
            rsp_tag_id    <= gnt_id;
        end
    end

    // Reset also masks a tag captured the cycle before it, so a lookup
    // in flight when reset arrives never surfaces.
    assign a_rsp_valid = rsp_tag_valid & ~reset & (rsp_tag_id == REQ_A);
    assign b_rsp_valid = rsp_tag_valid & ~reset & (rsp_tag_id == REQ_B);

    assign a_rsp_data = rom_dout;
    assign b_rsp_data = rom_dout;

endmodule

// File: tb/tb_gradient_rom_arbiter.sv
// Scoreboard bench for gradient_rom_arbiter with a behavioural ROM.
// Stimulus pushes expected colours; a negedge monitor pops and compares.
module tb_gradient_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prio_a = 1'b0;
    logic        a_req_valid = 1'b0;
    logic [7:0]  a_req_addr = 8'h00;
    logic        a_req_ready;
    logic        a_rsp_valid;
    logic [23:0] a_rsp_data;
    logic        b_req_valid = 1'b0;
    logic [7:0]  b_req_addr = 8'h00;
    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [23:0] b_rsp_data;
    logic [7:0]  rom_addr;
    logic [23:0] rom_dout = 24'h0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [23:0] d;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    gradient_rom_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .prio_a      (prio_a),
        .a_req_valid (a_req_valid),
        .a_req_addr  (a_req_addr),
        .a_req_ready (a_req_ready),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_data  (a_rsp_data),
        .b_req_valid (b_req_valid),
        .b_req_addr  (b_req_addr),
        .b_req_ready (b_req_ready),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_data  (b_rsp_data),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A};
    endfunction

    // Behavioural gradient ROM: registered output, one-cycle latency.
    always @(posedge clk) rom_dout <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest pending entry.
    always @(negedge clk) begin
        exp_t e;
        if (a_rsp_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rsp", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_rsp_data", a_rsp_data, e.d);
                chk("a_rsp_cycle", cyc, e.c);
            end
        end
        if (b_rsp_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_rsp_data", b_rsp_data, e.d);
                chk("b_rsp_cycle", cyc, e.c);
            end
        end
    end

    // One clock of stimulus. g: expected grant 0=none 1=A 2=B.
    task automatic step(input logic va, input logic [7:0] aa,
                        input logic vb, input logic [7:0] ab,
                        input logic pa, input logic rst,
                        input int g, input logic rsp);
        @(posedge clk);
        #1;
        a_req_valid = va;
        a_req_addr  = aa;
        b_req_valid = vb;
        b_req_addr  = ab;
        prio_a      = pa;
        reset       = rst;
        @(negedge clk);
        chk("a_req_ready", a_req_ready, g == 1);
        chk("b_req_ready", b_req_ready, g == 2);
        if (!rst && g == 1) chk("rom_addr_a", rom_addr, aa);
        if (!rst && g == 2) chk("rom_addr_b", rom_addr, ab);
        if (rsp && !rst && g == 1) qa.push_back('{rom_word(aa), cyc + 1});
        if (rsp && !rst && g == 2) qb.push_back('{rom_word(ab), cyc + 1});
    endtask

    initial begin
        // Reset for 3 cycles with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h44, 1, 8'h55, 0, 1, 1, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
        end
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("post_rst_a_rsp", a_rsp_valid, 0);
        chk("post_rst_b_rsp", b_rsp_valid, 0);
        chk("post_rst_rom_addr", rom_addr, 0);

        // Single A stream over every index.
        for (int i = 0; i < 256; i++) begin
            step(1, 8'(i), 0, 8'h00, 0, 0, 1, 1);
        end
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("addr_hold", rom_addr, 8'hFF);

        // Make B the last winner, then round-robin contention.
        step(0, 8'h00, 1, 8'h33, 0, 0, 2, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 8'h10, 1, 8'h20, 0, 0, (i % 2 == 0) ? 1 : 2, 1);
        end

        // Strict priority: A always wins, then B once A drops.
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h10, 1, 8'h20, 1, 0, 1, 1);
        end
        step(0, 8'h10, 1, 8'h20, 1, 0, 2, 1);

        // Mode flip: last grant is B -> A; priority -> A; RR -> B.
        step(1, 8'h61, 1, 8'h62, 0, 0, 1, 1);
        step(1, 8'h63, 1, 8'h64, 1, 0, 1, 1);
        step(1, 8'h65, 1, 8'h66, 0, 0, 2, 1);

        // Reset mid-flight: the 0x80 lookup must never respond.
        step(1, 8'h80, 0, 8'h00, 0, 0, 1, 0);
        step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        chk("midrst_a_rsp", a_rsp_valid, 0);
        step(1, 8'h11, 1, 8'h22, 0, 0, 1, 1);
        step(1, 8'h11, 1, 8'h22, 0, 0, 2, 1);

        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gradient_rom_arbiter.md
# gradient_rom_arbiter

Shares one single-port gradient colour ROM (24-bit colour per 8-bit index, registered output, one-cycle read latency) between two requesters: the waterfall line renderer (port A) and the colour-bar/legend renderer (port B). Valid/ready handshake on the request side, fire-and-forget tagged response one cycle after grant. Sits between both renderers and the gradient ROM instance, inside the display pipeline.

## Interface
- ADDR_WIDTH, 8, ROM index width
- DATA_WIDTH, 24, ROM colour word width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- prio_a  in  1  1 = A strict priority; 0 = round-robin
- a_req_valid  in  1  A lookup request
- a_req_addr  in  ADDR_WIDTH  A gradient index
- a_req_ready  out  1  A request accepted this cycle (combinational grant)
- a_rsp_valid  out  1  A colour valid (registered)
- a_rsp_data  out  DATA_WIDTH  A colour
- b_req_valid, b_req_addr, b_req_ready, b_rsp_valid, b_rsp_data: as A, for B
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_dout  in  DATA_WIDTH  ROM registered output

## Operation
- Transfer on port X when X_req_valid && X_req_ready in the same cycle. Requester holds valid and addr stable until accepted.
- At most one grant per cycle; the ROM is never idle while a valid request is pending.
- Both valid, prio_a=1: grant A. Both valid, prio_a=0: grant the port not granted last (last_grant register). Single valid: grant it regardless of mode.
- last_grant updates only on a transfer; reset value = B, so A wins the first tie.
- rom_addr = granted port's addr in the grant cycle; otherwise holds last granted address (addr_hold register, reset 0) to avoid needless ROM toggling.
- Tag pipeline: rsp_tag_valid and rsp_tag_id registered on transfer. Next cycle the tagged port's rsp_valid = 1; both X_rsp_data are driven from rom_dout (data meaningful only with rsp_valid).
- No response backpressure: consumers must accept rsp_valid when asserted.
- Back-to-back grants allowed every cycle (full throughput, 1 lookup/cycle).

## Timing
- Reset values: a_rsp_valid=0, b_rsp_valid=0, rom_addr=0, last_grant=B, tag pipeline empty. X_req_ready is combinational and may be high during reset; transfers in a reset cycle are discarded (no response issued).
- Latency: request accepted in cycle T, X_rsp_valid high in cycle T+1 exactly, for one cycle per transfer.
- Reset mid-operation: a transfer in cycle T with reset asserted in T+1 yields rsp_valid=0 in T+1 and after; no stale response ever emerges after reset.
- prio_a changes take effect in the same cycle (combinational into grant); last_grant unaffected by mode changes.
- Starvation: in round-robin, a continuously valid port waits at most 1 cycle. With prio_a=1, B may starve indefinitely (accepted: A carries line-time deadline).

## Structure
- Package gradient_pkg: ADDR_WIDTH/DATA_WIDTH defaults (8/24), requester ID constants (REQ_A=0, REQ_B=1).
- One sub-module: rr_arbiter2 (two-way grant logic with last_grant register and priority override); tag pipeline and address hold stay in the top.
- ROM itself is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold reset 3 cycles with both valid -> no rsp_valid during or the cycle after; rom_addr=0.
- Single A stream: A requests addr 0x00..0xFF back-to-back, B idle -> a_req_ready high every cycle, a_rsp_data equals ROM file word for each addr one cycle later, 256 responses.
- Round-robin contention: prio_a=0, both valid continuously, A addr 0x10, B addr 0x20 -> grants alternate A,B,A,B starting with A; responses alternate with matching colours.
- Strict priority: prio_a=1, both valid 10 cycles -> 10 A responses, 0 B; drop A -> B granted next cycle.
- Mode flip: round-robin with last grant A, set prio_a=1 with both valid -> A granted that cycle; clear prio_a -> B granted next.
- Reset mid-flight: transfer A addr 0x80 in cycle T, reset in T+1 -> a_rsp_valid stays 0; after reset first tie goes to A.
